// File: rtl/roi_capture_pkg.sv
// Package for the multi-window ROI capture stage.
// Holds the per-window operation codes, default widths and the fill colour that
// the shadow config holds after reset.
package roi_capture_pkg;

  localparam int unsigned DEFAULT_DATA_W  = 24;
  localparam int unsigned DEFAULT_NUM_WIN = 4;
  localparam int unsigned DEFAULT_CNT_W   = 12;

  // Per-window operation, 2 bits per window in win_mode.
  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_FILL  = 2'b01;
  localparam logic [1:0] MODE_INV   = 2'b10;
  localparam logic [1:0] MODE_BLACK = 2'b11;

  // Shadow fill after reset: every active pixel is white until the first load.
  localparam logic [23:0] RESET_FILL_RGB = 24'hffffff;

endpackage

// File: rtl/roi_capture_multi_if.sv
// Video + window-config bundle for roi_capture_multi.
//   i_rgb/i_hsync/i_vsync/i_de : input video
//   win_en/win_x0/win_x1/win_y0/win_y1/win_mode/fill_rgb : window config (live, shadowed in DUT)
//   cfg_update/cfg_pending     : config load request / load outstanding
//   o_rgb/o_hsync/o_vsync/o_de/o_hit : output video, 2 cycles behind input
// Modports: master = video source / config owner, slave = capture stage.
interface roi_capture_multi_if
  import roi_capture_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned NUM_WIN = DEFAULT_NUM_WIN,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
);

  logic [DATA_W-1:0]        i_rgb;
  logic                     i_hsync;
  logic                     i_vsync;
  logic                     i_de;
  logic [NUM_WIN-1:0]       win_en;
  logic [NUM_WIN*CNT_W-1:0] win_x0;
  logic [NUM_WIN*CNT_W-1:0] win_x1;
  logic [NUM_WIN*CNT_W-1:0] win_y0;
  logic [NUM_WIN*CNT_W-1:0] win_y1;
  logic [2*NUM_WIN-1:0]     win_mode;
  logic [DATA_W-1:0]        fill_rgb;
  logic                     cfg_update;
  logic                     cfg_pending;
  logic [DATA_W-1:0]        o_rgb;
  logic                     o_hsync;
  logic                     o_vsync;
  logic                     o_de;
  logic                     o_hit;

  modport master (
    output i_rgb, i_hsync, i_vsync, i_de,
    output win_en, win_x0, win_x1, win_y0, win_y1, win_mode, fill_rgb, cfg_update,
    input  cfg_pending, o_rgb, o_hsync, o_vsync, o_de, o_hit
  );

  modport slave (
    input  i_rgb, i_hsync, i_vsync, i_de,
    input  win_en, win_x0, win_x1, win_y0, win_y1, win_mode, fill_rgb, cfg_update,
    output cfg_pending, o_rgb, o_hsync, o_vsync, o_de, o_hit
  );

endinterface

// File: rtl/roi_window_hit.sv
// One ROI window: compares the pixel counters against the shadowed window
// rectangle (inclusive bounds) and registers the hit flag.
// With ROI_BORDER_EN defined it also registers a border flag (hit on any edge
// row/column of the window).
// Ports: pixelclk, reset_n, en, x0/x1/y0/y1 (window), hcnt/vcnt (position),
//        hit (registered), border (registered, ROI_BORDER_EN only).
module roi_window_hit
  import roi_capture_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             pixelclk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [CNT_W-1:0] x0,
  input  logic [CNT_W-1:0] x1,
  input  logic [CNT_W-1:0] y0,
  input  logic [CNT_W-1:0] y1,
  input  logic [CNT_W-1:0] hcnt,
  input  logic [CNT_W-1:0] vcnt,
  output logic             hit
`ifdef ROI_BORDER_EN
  ,
  output logic             border
`endif
);

  logic in_x, in_y, hit_d, hit_q;

  // An inverted range (x0 > x1 or y0 > y1) can never satisfy both bounds.
  assign in_x  = (hcnt >= x0) && (hcnt <= x1);
  assign in_y  = (vcnt >= y0) && (vcnt <= y1);
  assign hit_d = en && in_x && in_y;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) hit_q <= 1'b0;
    else          hit_q <= hit_d;
  end

  assign hit = hit_q;

`ifdef ROI_BORDER_EN
  logic border_d, border_q;

  assign border_d = hit_d && ((hcnt == x0) || (hcnt == x1) || (vcnt == y0) || (vcnt == y1));

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) border_q <= 1'b0;
    else          border_q <= border_d;
  end

  assign border = border_q;
`endif

endmodule

// File: rtl/roi_capture_multi.sv
// Multi-window region-of-interest capture stage.
// Derives pixel/line counters from de/vsync, holds a frame-synchronous shadow
// copy of the window config, and per pixel applies the op of the lowest-index
// enabled window containing it (pass/fill/invert/black); pixels outside every
// window get the fill colour. Fixed 2-cycle latency, never stalls.
// Ports: pixelclk (rising edge), reset_n (async, active low),
//        bus (roi_capture_multi_if.slave): video in/out, window config,
//        cfg_update / cfg_pending.
// Optional: define ROI_BORDER_EN to paint the edge pixels of the winning window
//           with BORDER_RGB regardless of its mode.
module roi_capture_multi
  import roi_capture_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned NUM_WIN = DEFAULT_NUM_WIN,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
`ifdef ROI_BORDER_EN
  ,
  parameter logic [DATA_W-1:0] BORDER_RGB = DATA_W'(24'hff0000)
`endif
) (
  input logic            pixelclk,
  input logic            reset_n,
  roi_capture_multi_if.slave bus
);

  // Input edge detection and counters.
  logic             vsync_q, de_q, vs_rise, de_fall;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;

  assign vs_rise = bus.i_vsync && !vsync_q;
  assign de_fall = de_q && !bus.i_de;

  always_comb begin
    hcnt_d = hcnt_q;
    if (!bus.i_de)            hcnt_d = '0;
    else if (hcnt_q != '1)    hcnt_d = hcnt_q + CNT_W'(1);
    vcnt_d = vcnt_q;
    if (vs_rise)                         vcnt_d = '0;
    else if (de_fall && (vcnt_q != '1))  vcnt_d = vcnt_q + CNT_W'(1);
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      vsync_q <= bus.i_vsync;
      de_q    <= bus.i_de;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Shadow config: loaded only on a vsync rising edge with a request outstanding
  // (or arriving on that very cycle), so a frame never sees a half-applied config.
  logic                     cfg_load, cfg_pending_q;
  logic [NUM_WIN-1:0]       sh_en_q;
  logic [NUM_WIN*CNT_W-1:0] sh_x0_q, sh_x1_q, sh_y0_q, sh_y1_q;
  logic [2*NUM_WIN-1:0]     sh_mode_q;
  logic [DATA_W-1:0]        sh_fill_q;

  assign cfg_load = vs_rise && (cfg_pending_q || bus.cfg_update);

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_pending_q <= 1'b0;
      sh_en_q       <= '0;
      sh_x0_q       <= '0;
      sh_x1_q       <= '0;
      sh_y0_q       <= '0;
      sh_y1_q       <= '0;
      sh_mode_q     <= '0;
      sh_fill_q     <= DATA_W'(RESET_FILL_RGB);
    end else if (cfg_load) begin
      cfg_pending_q <= 1'b0;
      sh_en_q       <= bus.win_en;
      sh_x0_q       <= bus.win_x0;
      sh_x1_q       <= bus.win_x1;
      sh_y0_q       <= bus.win_y0;
      sh_y1_q       <= bus.win_y1;
      sh_mode_q     <= bus.win_mode;
      sh_fill_q     <= bus.fill_rgb;
    end else if (bus.cfg_update) begin
      cfg_pending_q <= 1'b1;
    end
  end

  // Stage 1: per-window hit flags, pixel and syncs.
  logic [NUM_WIN-1:0] hit1;
`ifdef ROI_BORDER_EN
  logic [NUM_WIN-1:0] border1;
`endif

  for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
    roi_window_hit #(
      .CNT_W (CNT_W)
    ) u_hit (
      .pixelclk (pixelclk),
      .reset_n  (reset_n),
      .en       (sh_en_q[k]),
      .x0       (sh_x0_q[k*CNT_W +: CNT_W]),
      .x1       (sh_x1_q[k*CNT_W +: CNT_W]),
      .y0       (sh_y0_q[k*CNT_W +: CNT_W]),
      .y1       (sh_y1_q[k*CNT_W +: CNT_W]),
      .hcnt     (hcnt_q),
      .vcnt     (vcnt_q),
      .hit      (hit1[k])
`ifdef ROI_BORDER_EN
      ,
      .border   (border1[k])
`endif
    );
  end

  logic [DATA_W-1:0] pix1_q;
  logic              hs1_q, vs1_q, de1_q;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      pix1_q <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      de1_q  <= 1'b0;
    end else begin
      pix1_q <= bus.i_rgb;
      hs1_q  <= bus.i_hsync;
      vs1_q  <= bus.i_vsync;
      de1_q  <= bus.i_de;
    end
  end

  // Stage 2: priority select (lowest index wins) and apply the window op.
  // Shadow regs only change at a vsync rising edge, outside active video.
  logic              found;
  logic [1:0]        sel_mode;
  logic [DATA_W-1:0] rgb_d;
  logic              hit_d;
`ifdef ROI_BORDER_EN
  logic              sel_border;
`endif

  always_comb begin
    found    = 1'b0;
    sel_mode = MODE_PASS;
`ifdef ROI_BORDER_EN
    sel_border = 1'b0;
`endif
    // Scan downwards so the lowest-index hit is written last.
    for (int k = NUM_WIN - 1; k >= 0; k--) begin
      if (hit1[k]) begin
        found    = 1'b1;
        sel_mode = sh_mode_q[2*k +: 2];
`ifdef ROI_BORDER_EN
        sel_border = border1[k];
`endif
      end
    end
  end

  always_comb begin
    rgb_d = sh_fill_q;
    hit_d = 1'b0;
    if (!de1_q) begin
      rgb_d = '0;
    end else if (found) begin
      hit_d = 1'b1;
      case (sel_mode)
        MODE_PASS:  rgb_d = pix1_q;
        MODE_FILL:  rgb_d = sh_fill_q;
        MODE_INV:   rgb_d = ~pix1_q;
        MODE_BLACK: rgb_d = '0;
      endcase
`ifdef ROI_BORDER_EN
      if (sel_border) rgb_d = BORDER_RGB;
`endif
    end
  end

  logic [DATA_W-1:0] rgb_q;
  logic              hs2_q, vs2_q, de2_q, hit2_q;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q  <= '0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      de2_q  <= 1'b0;
      hit2_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      de2_q  <= de1_q;
      hit2_q <= hit_d;
    end
  end

  assign bus.o_rgb       = rgb_q;
  assign bus.o_hsync     = hs2_q;
  assign bus.o_vsync     = vs2_q;
  assign bus.o_de        = de2_q;
  assign bus.o_hit       = hit2_q;
  assign bus.cfg_pending = cfg_pending_q;

endmodule

// File: tb/tb_roi_capture_multi.sv
// Bench for roi_capture_multi: 8x4 frames, directed window scenarios plus
// randomised configs/pixels, checked against a frame-coordinate reference model.
module tb_roi_capture_multi;

  localparam int DW = 24;
  localparam int NW = 4;
  localparam int CW = 12;
  localparam int W  = 8;
  localparam int H  = 4;

  logic pixelclk = 1'b0;
  logic reset_n  = 1'b0;
  always #5 pixelclk = ~pixelclk;

  roi_capture_multi_if #(.DATA_W(DW), .NUM_WIN(NW), .CNT_W(CW)) bus ();

  roi_capture_multi #(
    .DATA_W  (DW),
    .NUM_WIN (NW),
    .CNT_W   (CW)
  ) dut (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  typedef struct {
    logic          en;
    logic [CW-1:0] x0, x1, y0, y1;
    logic [1:0]    mode;
  } win_t;

  typedef struct {
    logic [DW-1:0] rgb;
    logic          hs, vs, de, hit;
    int            x, y;
  } exp_t;

  win_t          cur [NW];   // values currently on the config inputs
  win_t          act [NW];   // config the frame in flight must use
  logic [DW-1:0] cur_fill, act_fill;
  logic          pend, prev_vs;

  exp_t          expq [$];
  logic [DW-1:0] got_rgb [H][W];
  logic          got_hit [H][W];
  logic [DW-1:0] drv     [H][W];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: first enabled window (lowest index) containing (x,y) decides.
  function automatic void model_px(input int x, input int y, input logic [DW-1:0] pix,
                                   output logic [DW-1:0] rgb, output logic hit);
    rgb = act_fill;
    hit = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (!hit && act[k].en && act[k].x0 <= x && x <= act[k].x1 &&
          act[k].y0 <= y && y <= act[k].y1) begin
        hit = 1'b1;
        case (act[k].mode)
          2'b00:   rgb = pix;
          2'b01:   rgb = act_fill;
          2'b10:   rgb = ~pix;
          default: rgb = '0;
        endcase
`ifdef ROI_BORDER_EN
        if (x == act[k].x0 || x == act[k].x1 || y == act[k].y0 || y == act[k].y1)
          rgb = 24'hff0000;
`endif
      end
    end
  endfunction

  task automatic drive_cfg();
    for (int k = 0; k < NW; k++) begin
      bus.win_en[k]              = cur[k].en;
      bus.win_x0[k*CW +: CW]     = cur[k].x0;
      bus.win_x1[k*CW +: CW]     = cur[k].x1;
      bus.win_y0[k*CW +: CW]     = cur[k].y0;
      bus.win_y1[k*CW +: CW]     = cur[k].y1;
      bus.win_mode[2*k +: 2]     = cur[k].mode;
    end
    bus.fill_rgb = cur_fill;
  endtask

  task automatic set_win(input int k, input logic en, input int x0, input int x1,
                         input int y0, input int y1, input logic [1:0] mode);
    cur[k].en   = en;
    cur[k].x0   = CW'(x0);
    cur[k].x1   = CW'(x1);
    cur[k].y0   = CW'(y0);
    cur[k].y1   = CW'(y1);
    cur[k].mode = mode;
  endtask

  // One pixel-clock cycle of stimulus; records what the outputs must be 2 cycles on.
  task automatic step(input logic [DW-1:0] pix, input logic hs, input logic vs,
                      input logic de, input int x, input int y, input logic upd);
    exp_t e;
    @(posedge pixelclk);
    #1;
    bus.i_rgb      = pix;
    bus.i_hsync    = hs;
    bus.i_vsync    = vs;
    bus.i_de       = de;
    bus.cfg_update = upd;
    if (vs && !prev_vs && (pend || upd)) begin
      act      = cur;
      act_fill = cur_fill;
      pend     = 1'b0;
    end else if (upd) begin
      pend = 1'b1;
    end
    prev_vs = vs;
    e.hs = hs; e.vs = vs; e.de = de; e.x = x; e.y = y;
    if (de) begin
      model_px(x, y, pix, e.rgb, e.hit);
      drv[y][x] = pix;
    end else begin
      e.rgb = '0;
      e.hit = 1'b0;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n, input logic upd);
    for (int i = 0; i < n; i++) step(DW'($urandom), 1'b0, 1'b0, 1'b0, -1, -1, upd && i == 0);
  endtask

  // pix_sel 0: pixel = column index, 1: random pixels.
  task automatic frame(input int pix_sel, input int upd_y, input int upd_x, input logic vs_upd);
    step(DW'($urandom), 1'b0, 1'b1, 1'b0, -1, -1, vs_upd);
    step(DW'($urandom), 1'b0, 1'b1, 1'b0, -1, -1, 1'b0);
    step(DW'($urandom), 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    step(DW'($urandom), 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        logic [DW-1:0] p;
        p = (pix_sel == 0) ? DW'(x) : DW'($urandom);
        step(p, 1'b0, 1'b0, 1'b1, x, y, (y == upd_y) && (x == upd_x));
      end
      step(DW'($urandom), 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
      step(DW'($urandom), 1'b1, 1'b0, 1'b0, -1, -1, 1'b0);
      step(DW'($urandom), 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    end
  endtask

  // Output sampled on the falling edge; the entry driven 2 rising edges earlier applies.
  always @(negedge pixelclk) begin
    if (expq.size() >= 3) begin
      exp_t e;
      e = expq.pop_front();
      n_cmp++;
      if (bus.o_rgb !== e.rgb || bus.o_hsync !== e.hs || bus.o_vsync !== e.vs ||
          bus.o_de !== e.de || bus.o_hit !== e.hit) begin
        n_err++;
        $display("FAIL pipe x=%0d y=%0d: rgb %h hs %b vs %b de %b hit %b, expected rgb %h hs %b vs %b de %b hit %b",
                 e.x, e.y, bus.o_rgb, bus.o_hsync, bus.o_vsync, bus.o_de, bus.o_hit,
                 e.rgb, e.hs, e.vs, e.de, e.hit);
      end
      if (e.de) begin
        got_rgb[e.y][e.x] = bus.o_rgb;
        got_hit[e.y][e.x] = bus.o_hit;
      end
    end
  end

  initial begin
    logic [DW-1:0] inv;
    for (int k = 0; k < NW; k++) set_win(k, 1'b0, 0, 0, 0, 0, 2'b00);
    act      = cur;
    act_fill = 24'hffffff;
    cur_fill = 24'h000000;
    pend     = 1'b0;
    prev_vs  = 1'b0;
    drive_cfg();
    bus.cfg_update = 1'b0;
    // Activity on the video inputs during reset must not reach the outputs.
    bus.i_rgb   = 24'habcdef;
    bus.i_de    = 1'b1;
    bus.i_vsync = 1'b1;
    bus.i_hsync = 1'b1;
    repeat (3) @(posedge pixelclk);
    #1;
    chk("reset o_rgb", 32'(bus.o_rgb), 32'h0);
    chk("reset o_hit", 32'(bus.o_hit), 32'h0);
    chk("reset syncs/de", {29'h0, bus.o_hsync, bus.o_vsync, bus.o_de}, 32'h0);
    chk("reset cfg_pending", 32'(bus.cfg_pending), 32'h0);
    bus.i_de    = 1'b0;
    bus.i_vsync = 1'b0;
    bus.i_hsync = 1'b0;
    @(negedge pixelclk);
    reset_n = 1'b1;
    idle(3, 1'b0);

    // No config loaded: everything white, no hits.
    frame(1, -1, -1, 1'b0);
    chk("noconf rgb(0,0)", 32'(got_rgb[0][0]), 32'hffffff);
    chk("noconf rgb(7,3)", 32'(got_rgb[3][7]), 32'hffffff);
    chk("noconf hit(4,2)", 32'(got_hit[2][4]), 32'h0);

    // Window 0 pass over (2,1)-(5,2), pixel = column.
    cur_fill = 24'h123456;
    set_win(0, 1'b1, 2, 5, 1, 2, 2'b00);
    drive_cfg();
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("pending after update", 32'(bus.cfg_pending), 32'h1);
    frame(0, -1, -1, 1'b0);
    chk("pass rgb(2,1)", 32'(got_rgb[1][2]), 32'h000002);
    chk("pass rgb(5,2)", 32'(got_rgb[2][5]), 32'h000005);
    chk("pass rgb(1,1)", 32'(got_rgb[1][1]), 32'h123456);
    chk("pass rgb(6,1)", 32'(got_rgb[1][6]), 32'h123456);
    chk("pass rgb(3,0)", 32'(got_rgb[0][3]), 32'h123456);
    chk("pass hit(5,2)", 32'(got_hit[2][5]), 32'h1);
    chk("pass hit(3,3)", 32'(got_hit[3][3]), 32'h0);
    chk("pending after load", 32'(bus.cfg_pending), 32'h0);

    // Overlapping windows: window 0 invert beats window 1 fill.
    cur_fill = 24'h00ff00;
    set_win(0, 1'b1, 0, 7, 0, 3, 2'b10);
    set_win(1, 1'b1, 0, 7, 0, 3, 2'b01);
    drive_cfg();
    idle(2, 1'b1);
    frame(1, -1, -1, 1'b0);
    inv = ~drv[1][1];
    chk("prio invert rgb(1,1)", 32'(got_rgb[1][1]), 32'(inv));
    chk("prio hit(0,0)", 32'(got_hit[0][0]), 32'h1);
    cur[0].en = 1'b0;
    drive_cfg();
    idle(2, 1'b1);
    frame(1, -1, -1, 1'b0);
    chk("win1 fill rgb(3,2)", 32'(got_rgb[2][3]), 32'h00ff00);

    // Mid-frame update: current frame keeps the old window.
    set_win(0, 1'b1, 2, 5, 0, 3, 2'b00);
    cur[1].en = 1'b0;
    drive_cfg();
    idle(2, 1'b1);
    frame(0, -1, -1, 1'b0);
    cur[0].x0 = CW'(4);
    drive_cfg();
    frame(0, 1, 3, 1'b0);
    chk("midframe old rgb(2,2)", 32'(got_rgb[2][2]), 32'h000002);
    chk("midframe pending", 32'(bus.cfg_pending), 32'h1);
    frame(0, -1, -1, 1'b0);
    chk("newframe rgb(2,2)", 32'(got_rgb[2][2]), 32'h00ff00);
    chk("newframe rgb(4,2)", 32'(got_rgb[2][4]), 32'h000004);
    chk("newframe pending", 32'(bus.cfg_pending), 32'h0);

    // Inverted range never hits.
    set_win(0, 1'b1, 6, 3, 0, 3, 2'b00);
    drive_cfg();
    idle(2, 1'b1);
    frame(1, -1, -1, 1'b0);
    chk("x0>x1 hit(4,1)", 32'(got_hit[1][4]), 32'h0);
    chk("x0>x1 hit(6,1)", 32'(got_hit[1][6]), 32'h0);

    // Update on the vsync rising edge itself loads on that edge.
    set_win(0, 1'b1, 0, 7, 0, 3, 2'b11);
    drive_cfg();
    frame(1, -1, -1, 1'b1);
    chk("vs-update black rgb(0,0)", 32'(got_rgb[0][0]), 32'h0);
    chk("vs-update hit(0,0)", 32'(got_hit[0][0]), 32'h1);
    chk("vs-update pending", 32'(bus.cfg_pending), 32'h0);

    // Window edges: border colour only with the border feature.
    cur_fill = 24'h0000ff;
    set_win(0, 1'b1, 1, 4, 1, 2, 2'b00);
    drive_cfg();
    idle(2, 1'b1);
    frame(0, -1, -1, 1'b0);
`ifdef ROI_BORDER_EN
    chk("border rgb(1,1)", 32'(got_rgb[1][1]), 32'hff0000);
    chk("border rgb(3,2)", 32'(got_rgb[2][3]), 32'hff0000);
`else
    chk("edge rgb(1,1)", 32'(got_rgb[1][1]), 32'h000001);
    chk("edge rgb(3,2)", 32'(got_rgb[2][3]), 32'h000003);
`endif
    chk("edge outside rgb(1,0)", 32'(got_rgb[0][1]), 32'h0000ff);

    // Randomised configs, pixels and update timing.
    for (int f = 0; f < 10; f++) begin
      int sel;
      for (int k = 0; k < NW; k++)
        set_win(k, 1'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom_range(0, 5), $urandom_range(0, 5), 2'($urandom_range(0, 3)));
      cur_fill = DW'($urandom);
      drive_cfg();
      sel = $urandom_range(0, 2);
      if (sel == 0) idle(2, 1'b1);
      frame(1, (sel == 1) ? $urandom_range(0, H - 1) : -1, $urandom_range(0, W - 1), sel == 2);
    end
    idle(4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
